// File: rtl/flash_spi_responder.sv
// flash_spi_responder: SPI flash target model clocked entirely from clk.
// SCK/CS/SI are synchronised and edge-detected; a byte-wide array of
// 2^MEM_AW entries is read by 4READ and programmed by 4PP.
// Optional build macro FLASH_RESP_WIP_EN: 4PP data is buffered, WIP is held
// for WIP_CYCLES after CS rises, and the buffer is committed when WIP clears.
module flash_spi_responder #(
    parameter int unsigned MEM_AW     = 8,
    parameter logic [7:0]  MFG_ID     = 8'h01,
    parameter logic [7:0]  DEV_ID     = 8'h19,
    parameter int unsigned WIP_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flash_SCK,
    input  logic       flash_CS,
    input  logic       flash_SI,
    output logic       flash_SO,
    output logic       flash_SO_oe,
    output logic       cmd_strobe,
    output logic [7:0] last_cmd,
    output logic [7:0] sr1,
    output logic [7:0] bar
);
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_BRRD  = 8'h16;
    localparam logic [7:0] OP_BRWR  = 8'h17;
    localparam logic [7:0] OP_REMS  = 8'h90;
    localparam logic [7:0] OP_READ4 = 8'h13;
    localparam logic [7:0] OP_PP4   = 8'h12;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DOUT, DIN, IGNORE} state_t;

    state_t            state;
    logic [2:0]        sck_s, cs_s;
    logic [1:0]        si_s;
    logic [2:0]        bit_cnt, out_cnt, addr_left;
    logic [4:0]        tot_bits;
    logic [7:0]        shift_in, op, out_shift, src_byte, new_byte, mem_wd;
    logic [23:0]       addr_sh;
    logic [MEM_AW-1:0] idx, mem_wa;
    logic              wel, wel_dec, rems_sel, load_pend, mem_we, wip, busy;
    logic              sck_rise, sck_fall, cs_rise, cs_fall, byte_done;

    // Array stored inverted so an all-zero power-up image reads as erased 0xFF.
    logic [7:0]        mem_n [DEPTH];

`ifdef FLASH_RESP_WIP_EN
    localparam int unsigned WIP_W = $clog2(WIP_CYCLES + 1);
    logic [WIP_W-1:0]  wip_cnt;
    logic [MEM_AW:0]   buf_cnt, cm_left;
    logic [MEM_AW-1:0] buf_wa, cm_rd, cm_wa, pp_start;
    logic [7:0]        buf_wd;
    logic              buf_we, commit;
    logic [7:0]        pbuf [DEPTH];
    assign busy = wip | commit;
`else
    logic unused_cfg;
    assign unused_cfg = ^WIP_CYCLES;
    assign wip  = 1'b0;
    assign busy = 1'b0;
`endif

    assign sck_rise  = ~cs_s[1] & sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~cs_s[1] & ~sck_s[1] & sck_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign new_byte  = {shift_in[6:0], si_s[1]};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign sr1       = {6'b0, wel, wip};

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_s <= '0;
            cs_s  <= '1;
            si_s  <= '0;
        end else begin
            sck_s <= {sck_s[1:0], flash_SCK};
            cs_s  <= {cs_s[1:0], flash_CS};
            si_s  <= {si_s[0], flash_SI};
        end
    end

    // Next byte to shift out for the current read-type command
    always_comb begin
        src_byte = ~mem_n[idx];
        case (op)
            OP_RDSR1: src_byte = sr1;
            OP_BRRD:  src_byte = bar;
            OP_REMS:  src_byte = rems_sel ? DEV_ID : MFG_ID;
            default:  ;
        endcase
    end

    // Array program port: AND of old contents with new data (OR when inverted)
    always_ff @(posedge clk) begin
        if (mem_we) mem_n[mem_wa] <= mem_n[mem_wa] | ~mem_wd;
    end

`ifdef FLASH_RESP_WIP_EN
    // Page buffer holding 4PP data until WIP clears
    always_ff @(posedge clk) begin
        if (buf_we) pbuf[buf_wa] <= buf_wd;
    end
`endif

    // Protocol FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tot_bits    <= '0;
            out_cnt     <= '0;
            addr_left   <= '0;
            shift_in    <= '0;
            addr_sh     <= '0;
            op          <= '0;
            out_shift   <= '0;
            last_cmd    <= '0;
            bar         <= '0;
            cmd_strobe  <= 1'b0;
            wel         <= 1'b0;
            wel_dec     <= 1'b0;
            rems_sel    <= 1'b0;
            load_pend   <= 1'b0;
            idx         <= '0;
            flash_SO    <= 1'b0;
            flash_SO_oe <= 1'b0;
            mem_we      <= 1'b0;
            mem_wa      <= '0;
            mem_wd      <= '0;
`ifdef FLASH_RESP_WIP_EN
            wip         <= 1'b0;
            wip_cnt     <= '0;
            buf_cnt     <= '0;
            cm_left     <= '0;
            buf_wa      <= '0;
            cm_rd       <= '0;
            cm_wa       <= '0;
            pp_start    <= '0;
            buf_wd      <= '0;
            buf_we      <= 1'b0;
            commit      <= 1'b0;
`endif
        end else begin
            cmd_strobe <= 1'b0;
            mem_we     <= 1'b0;
`ifdef FLASH_RESP_WIP_EN
            buf_we <= 1'b0;
            if (wip) begin
                if (wip_cnt <= WIP_W'(1)) begin
                    wip    <= 1'b0;
                    commit <= 1'b1;
                    cm_rd  <= '0;
                    cm_wa  <= pp_start;
                end else begin
                    wip_cnt <= wip_cnt - WIP_W'(1);
                end
            end
            if (commit) begin
                mem_we  <= 1'b1;
                mem_wa  <= cm_wa;
                mem_wd  <= pbuf[cm_rd];
                cm_wa   <= cm_wa + MEM_AW'(1);
                cm_rd   <= cm_rd + MEM_AW'(1);
                cm_left <= cm_left - (MEM_AW+1)'(1);
                if (cm_left == (MEM_AW+1)'(1)) commit <= 1'b0;
            end
`endif
            if (cs_rise && state != IDLE) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                load_pend   <= 1'b0;
                flash_SO_oe <= 1'b0;
                if (state == IGNORE && op == OP_WREN && tot_bits == 5'd8) wel <= 1'b1;
                if (state == DIN && op == OP_BRWR && tot_bits == 5'd16) bar <= shift_in;
                if (op == OP_PP4) begin
                    wel <= 1'b0;
`ifdef FLASH_RESP_WIP_EN
                    if (wel_dec && buf_cnt != '0) begin
                        wip     <= 1'b1;
                        wip_cnt <= WIP_W'(WIP_CYCLES);
                        cm_left <= buf_cnt;
                    end
`endif
                end
            end else begin
                if (sck_rise && state != IDLE) begin
                    shift_in <= new_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (tot_bits != '1) tot_bits <= tot_bits + 5'd1;
                end
                case (state)
                    IDLE: if (cs_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        tot_bits <= '0;
                        op       <= '0;
                    end
                    CMD: if (byte_done) begin
                        last_cmd   <= new_byte;
                        cmd_strobe <= 1'b1;
                        wel_dec    <= wel;
                        addr_left  <= 3'd4;
`ifdef FLASH_RESP_WIP_EN
                        buf_cnt    <= '0;
`endif
                        // While busy only RDSR1 is honoured; op is cleared so
                        // nothing downstream treats the opcode as live.
                        if (busy && new_byte != OP_RDSR1) begin
                            op    <= '0;
                            state <= IGNORE;
                        end else begin
                            op <= new_byte;
                            case (new_byte)
                                OP_RDSR1, OP_BRRD: begin
                                    state     <= DOUT;
                                    load_pend <= 1'b1;
                                end
                                OP_BRWR: state <= DIN;
                                OP_REMS: begin
                                    state     <= ADDR;
                                    addr_left <= 3'd3;
                                end
                                OP_READ4, OP_PP4: state <= ADDR;
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (byte_done) begin
                        addr_sh   <= {addr_sh[15:0], new_byte};
                        addr_left <= addr_left - 3'd1;
                        if (addr_left == 3'd1) begin
                            idx      <= MEM_AW'({addr_sh, new_byte});
                            rems_sel <= new_byte[0];
`ifdef FLASH_RESP_WIP_EN
                            pp_start <= MEM_AW'({addr_sh, new_byte});
`endif
                            if (op == OP_PP4) begin
                                state <= DIN;
                            end else begin
                                state     <= DOUT;
                                load_pend <= 1'b1;
                            end
                        end
                    end
                    DOUT: if (load_pend) begin
                        out_shift   <= src_byte;
                        idx         <= idx + MEM_AW'(1);
                        rems_sel    <= ~rems_sel;
                        out_cnt     <= '0;
                        load_pend   <= 1'b0;
                        flash_SO_oe <= 1'b1;
                    end else if (sck_fall) begin
                        flash_SO <= out_shift[7];
                        out_cnt  <= out_cnt + 3'd1;
                        if (out_cnt == 3'd7) begin
                            out_shift <= src_byte;
                            idx       <= idx + MEM_AW'(1);
                            rems_sel  <= ~rems_sel;
                        end else begin
                            out_shift <= {out_shift[6:0], 1'b0};
                        end
                    end
                    DIN: if (byte_done && op == OP_PP4 && wel_dec) begin
`ifdef FLASH_RESP_WIP_EN
                        if (!buf_cnt[MEM_AW]) begin
                            buf_we  <= 1'b1;
                            buf_wa  <= buf_cnt[MEM_AW-1:0];
                            buf_wd  <= new_byte;
                            buf_cnt <= buf_cnt + (MEM_AW+1)'(1);
                        end
`else
                        mem_we <= 1'b1;
                        mem_wa <= idx;
                        mem_wd <= new_byte;
                        idx    <= idx + MEM_AW'(1);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/flash_spi_responder.md
FLASH_SPI_RESPONDER -- requirements
Module: flash_spi_responder

Interface
REQ-001 Parameter MEM_AW, default 8, sets the address width of the internal byte array (2^MEM_AW bytes, erased value 8'hFF).
REQ-002 Parameter MFG_ID, default 8'h01, is the manufacturer ID returned by REMS.
REQ-003 Parameter DEV_ID, default 8'h19, is the device ID returned by REMS.
REQ-004 Parameter WIP_CYCLES, default 64, is the busy duration in clk cycles after a page program.
REQ-005 Port clk, input, 1 bit: the single system clock; clk is the only clock and clocks all logic.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port flash_SCK, input, 1 bit: SPI clock from the master, mode 0.
REQ-008 Port flash_CS, input, 1 bit: chip select, active-low.
REQ-009 Port flash_SI, input, 1 bit: serial data from the master.
REQ-010 Port flash_SO, output, 1 bit: serial data to the master.
REQ-011 Port flash_SO_oe, output, 1 bit: SO drive enable; high only while CS is low during a data-out phase.
REQ-012 Port cmd_strobe, output, 1 bit: one-clk pulse when a complete opcode byte is received.
REQ-013 Port last_cmd, output, 8 bits: most recently received opcode.
REQ-014 Port sr1, output, 8 bits: Status Register 1; bit0 is WIP, bit1 is WEL, all other bits are 0.
REQ-015 Port bar, output, 8 bits: Bank Address Register.

Function
REQ-016 SCK, CS and SI shall pass through 2-flop synchronizers; edges shall be detected in the clk domain; legal operation requires f_SCK <= f_clk/4.
REQ-017 SI shall be sampled on each synchronized SCK rising edge, MSB first; SO shall change only on SCK falling edges.
REQ-018 The FSM shall have states IDLE, CMD, ADDR, DOUT, DIN and IGNORE; a CS falling edge shall move IDLE to CMD with the bit count cleared.
REQ-019 In CMD, after 8 bits the opcode shall be decoded as follows:
- 0x06 WREN -> IGNORE
- 0x05 RDSR1 -> DOUT
- 0x16 BRRD -> DOUT
- 0x17 BRWR -> DIN
- 0x90 REMS -> ADDR (3 bytes)
- 0x13 4READ -> ADDR (4 bytes)
- 0x12 4PP -> ADDR (4 bytes)
- any other opcode -> IGNORE
REQ-020 ADDR shall shift in address bytes MSB first, then go to DOUT for 4READ and REMS, or to DIN for 4PP.
REQ-021 The byte array index shall be address[MEM_AW-1:0]; the upper address bits shall be ignored.
REQ-022 The first DOUT byte shall be loaded in the clk cycle after the 8th SCK rise of the last opcode/address byte; its MSB shall appear on SO at the next SCK falling edge.
REQ-023 RDSR1 shall return sr1 repeatedly and BRRD shall return bar repeatedly until CS rises.
REQ-024 REMS shall return MFG_ID then DEV_ID, alternating; if address bit0 is 1, DEV_ID shall be returned first.
REQ-025 4READ shall return mem[index]; the index shall increment after each byte and wrap from 2^MEM_AW-1 to 0.
REQ-026 4PP shall program each received byte as mem[index] = mem[index] AND data, increment the index with wrap, and program only when WEL was 1 at opcode decode.
REQ-027 BRWR shall write the first DIN byte to bar only when exactly 16 bits are clocked before CS rises.
REQ-028 WREN shall set WEL on the CS rising edge only if exactly 8 bits were clocked.
REQ-029 A CS rising edge shall end the transaction after any 4PP and clear WEL.
REQ-030 While WIP=1, every opcode except RDSR1 shall be treated as IGNORE.
REQ-031 A CS rising edge in any state shall return the FSM to IDLE, discard any partial byte, and deassert flash_SO_oe in the same cycle.
REQ-032 cmd_strobe shall pulse, and last_cmd shall update, in the clk cycle the opcode completes, including for ignored opcodes.

Reset
REQ-033 On reset low, asynchronously: FSM = IDLE, sr1 = 0, bar = 0, last_cmd = 0, cmd_strobe = 0, flash_SO = 0, flash_SO_oe = 0, bit count = 0.
REQ-034 The byte array contents shall not be affected by reset.
REQ-035 A reset asserted mid-transaction shall abort it; a 4PP write already in progress shall not be committed.

Configuration
REQ-036 With FLASH_RESP_WIP_EN defined, the CS rising edge that ends a 4PP (with WEL=1 and at least 1 data byte) shall set WIP for WIP_CYCLES clk cycles, and the data bytes shall be committed only when WIP clears.
REQ-037 Without FLASH_RESP_WIP_EN, WIP shall be tied 0 and 4PP bytes shall be committed immediately as they are received.

Verification
REQ-038 Send 0x17, 0x80, then 0x16 and one read byte -> bar = 8'h80 and the read returns 8'h80.
REQ-039 Send 0x90, 00 00 00, then two read bytes -> reads return 8'h01, 8'h19; with address 00 00 01 -> reads return 8'h19, 8'h01.
REQ-040 Send 0x06, then 0x05 and one read byte -> the read returns 8'h02; then send 0x12, address 01 02 03 04, data 0x0B..0x1E -> mem[0x04..] holds those bytes and a following RDSR1 returns 8'h00 (with WIP_EN: returns 8'h01 until WIP_CYCLES elapse).
REQ-041 Send 0x12 without a prior WREN, data 0x00 -> mem unchanged (reads back 8'hFF); then 0x13 with address 0x000000FE and 4 read bytes -> returns mem[FE], mem[FF], mem[00], mem[01].
REQ-042 Raise CS after 5 bits of 0x06 -> WEL stays 0, FSM returns to IDLE, and flash_SO_oe = 0.
REQ-043 Assert reset during a 4READ data byte -> flash_SO_oe drops immediately and all outputs take their REQ-033 values.
